fifo_wptr_full: RTL
===================

# fifo_wptr_full

Write-side pointer and full-flag generator for the asynchronous FIFO. It is the producer end of the pointer-crossing path: it advances the binary write pointer on accepted writes and drives the registered Gray-coded write pointer that the read domain's `fifo_synchronizer` samples. It also consumes the read pointer already synchronized into the write domain and derives `wfull`, `walmost_full` and a fill count. It sits in the write clock domain, between the AXI write-channel front end and the dual-port FIFO memory.

## Interface
- `PTR_WIDTH`, 6, address width; FIFO depth DEPTH = 2**PTR_WIDTH; pointers are PTR_WIDTH+1 bits.
- `AF_THRESH`, 4, `walmost_full` asserts when free entries <= AF_THRESH; legal range 1..DEPTH-1.

- `clk`  in  1  write-domain clock.
- `resetn`  in  1  synchronous, active-high reset (asserted = 1, sampled on `clk` rising edge).
- `winc`  in  1  write request from the front end.
- `wq2_rptr`  in  PTR_WIDTH+1  Gray read pointer, already synchronized into `clk`.
- `wr_en`  out  1  memory write strobe, combinational = `winc & ~wfull`.
- `waddr`  out  PTR_WIDTH  memory write address = low PTR_WIDTH bits of the binary pointer.
- `wptr`  out  PTR_WIDTH+1  registered Gray write pointer, sent to the read-side synchronizer.
- `wfull`  out  1  registered full flag.
- `walmost_full`  out  1  registered almost-full flag.
- `wcount`  out  PTR_WIDTH+1  registered occupancy as seen from the write domain, 0..DEPTH.
- `wovf`  out  1  sticky overflow flag (see Configuration).

## Operation
- State: `wbin` and `wptr` (PTR_WIDTH+1 each), `wfull`, `walmost_full`, `wcount`, `wovf`.
- Next-state values: `wbin_nxt = wbin + wr_en` (mod 2**(PTR_WIDTH+1)); `wgray_nxt = wbin_nxt ^ (wbin_nxt >> 1)`.
- Full: `wgray_nxt == {~wq2_rptr[PTR_WIDTH:PTR_WIDTH-1], wq2_rptr[PTR_WIDTH-2:0]}`.
- Count: `wbin_nxt - gray2bin(wq2_rptr)`, modulo 2**(PTR_WIDTH+1), which gives 0..DEPTH.
- Almost-full: `count_nxt >= DEPTH - AF_THRESH`.
- Write while full: `wr_en = 0`, and the pointer does not move. This is not an error path for the memory.
- Wrap-around: `wbin` rolls from 2**(PTR_WIDTH+1)-1 to 0. `wptr` changes exactly one bit on every increment, including at the wrap.
- `wptr` only ever changes by one Gray step per cycle. It is never driven by combinational logic.
- Reset: all outputs that are registers go to 0: `wbin`, `wptr`, `waddr`, `wfull`, `walmost_full`, `wcount`, `wovf`. `wr_en` follows `winc` while in reset, because `wfull` = 0.
- A reset in the middle of a burst discards the pointer. Resetting the read side consistently is the system's responsibility.

## Timing
- Accepted write at edge N: `waddr`/`wptr` advance at edge N, so the new values are visible in cycle N+1.
- The `wfull` flag for that write is valid in the same cycle N+1. There is no bubble: back-to-back writes stop exactly at DEPTH entries.
- A change on `wq2_rptr` in cycle N is reflected in `wfull`/`walmost_full`/`wcount` at edge N, so it is visible in N+1. This 1-cycle lag is pessimistic (safe).
- Simultaneous events: an accepted write and a `wq2_rptr` advance in the same cycle are both applied in the same next-state computation.
- `wr_en` has zero latency from `winc` and depends on the registered `wfull` only.

## Configuration
- `FIFO_WR_OVF_FLAG_EN` defined:
  - `wovf` sets at the edge where `winc & wfull`.
  - It holds until `resetn`.
- Not defined: `wovf` is tied to 0 and the register is not built.

## Structure
- Shared package `fifo_pkg` holds:
  - the `bin2gray` and `gray2bin` functions;
  - the default `PTR_WIDTH` constant, shared with `fifo_synchronizer` and the read-side block.
- One sub-module, `fifo_gray2bin`:
  - parameterized by width, purely combinational;
  - converts `wq2_rptr` to binary;
  - is reused by the read-side empty logic.

## Test plan
- Reset with `winc`=1 for 2 cycles → `wptr`=0, `waddr`=0, `wfull`=0, `walmost_full`=0, `wcount`=0, `wovf`=0. Release: the first write gives `wptr`=7'h01.
- 64 consecutive writes, `wq2_rptr`=0:
  - `walmost_full` rises when `wcount`=60;
  - after the 64th write `wfull`=1, `wcount`=64, `wptr`=7'h60, `waddr`=0.
- Full, then `winc`=1 for 3 cycles → `wr_en`=0, `wptr` stays 7'h60. `wovf`=1 with the macro defined, 0 without it.
- Full, then `wq2_rptr` ← 7'h01 → next cycle `wfull`=0, `wcount`=63. A write in that same cycle gives `wfull`=1 again on the following edge.
- Wrap: with `wq2_rptr` kept within DEPTH, run `wbin` from 127 to 0 → `wptr` goes 7'h40 → 7'h00, with exactly one bit changing on each step.
- Random `winc`/`wq2_rptr` stepping (Gray steps of one bit per cycle, legal distance) → checker: `wptr` Hamming distance ≤1 per cycle, and `wcount` equals the model's occupancy.

Source files
------------

// File: rtl/fifo_pkg.sv
// Shared async-FIFO helpers: Gray/binary conversion
// and the default pointer width used by both clock domains.
package fifo_pkg;

  localparam int PTR_WIDTH_DEF = 6;

  function automatic logic [31:0] bin2gray(
    input logic [31:0] b
  );
    return b ^ (b >> 1);
  endfunction

  function automatic logic [31:0] gray2bin(
    input logic [31:0] g
  );
    logic [31:0] b;
    b = g;
    for (int i = 1; i < 32; i++) begin
      b = b ^ (g >> i);
    end
    return b;
  endfunction

endpackage

// File: rtl/fifo_gray2bin.sv
// Width-parameterized combinational Gray-to-binary
// converter, shared by the write-full and read-empty logic.
module fifo_gray2bin #(
  parameter int W = 7
) (
  input  logic [W-1:0] gray,
  output logic [W-1:0] bin
);

  // Each binary bit is the XOR of all Gray bits at or above it
  for (genvar i = 0; i < W; i++) begin : g_bit
    assign bin[i] = ^gray[W-1:i];
  end

endmodule

// File: rtl/fifo_wptr_full.sv
// Write-side pointer, full/almost-full and fill-count logic.
// Optional sticky overflow flag: define FIFO_WR_OVF_FLAG_EN.
module fifo_wptr_full
  import fifo_pkg::*;
#(
  parameter int PTR_WIDTH = PTR_WIDTH_DEF,
  parameter int AF_THRESH = 4
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 winc,
  input  logic [PTR_WIDTH:0]   wq2_rptr,
  output logic                 wr_en,
  output logic [PTR_WIDTH-1:0] waddr,
  output logic [PTR_WIDTH:0]   wptr,
  output logic                 wfull,
  output logic                 walmost_full,
  output logic [PTR_WIDTH:0]   wcount,
  output logic                 wovf
);

  localparam int PW1   = PTR_WIDTH + 1;
  localparam int DEPTH = 1 << PTR_WIDTH;
  localparam logic [PTR_WIDTH:0] AF_LVL =
    PW1'(DEPTH - AF_THRESH);

  logic [PTR_WIDTH:0] wbin;
  logic [PTR_WIDTH:0] wbin_nxt;
  logic [PTR_WIDTH:0] wgray_nxt;
  logic [PTR_WIDTH:0] rbin;
  logic [PTR_WIDTH:0] cnt_nxt;
  logic [PTR_WIDTH:0] full_cmp;
  logic               full_nxt;
  logic               af_nxt;

  fifo_gray2bin #(
    .W (PW1)
  ) u_rg2b (
    .gray (wq2_rptr),
    .bin  (rbin)
  );

  assign wr_en     = winc & ~wfull;
  assign waddr     = wbin[PTR_WIDTH-1:0];
  assign wbin_nxt  = wbin + {{PTR_WIDTH{1'b0}}, wr_en};
  assign wgray_nxt = PW1'(bin2gray(32'(wbin_nxt)));

  // Full when the write pointer is one lap ahead: top two
  // Gray bits inverted, the rest equal
  assign full_cmp = {~wq2_rptr[PTR_WIDTH:PTR_WIDTH-1],
                     wq2_rptr[PTR_WIDTH-2:0]};
  assign full_nxt = (wgray_nxt == full_cmp);
  assign cnt_nxt  = wbin_nxt - rbin;
  assign af_nxt   = (cnt_nxt >= AF_LVL);

  // Pointer and flag registers, all from next-state values
  always_ff @(posedge clk) begin
    if (resetn) begin
      wbin         <= '0;
      wptr         <= '0;
      wfull        <= 1'b0;
      walmost_full <= 1'b0;
      wcount       <= '0;
    end else begin
      wbin         <= wbin_nxt;
      wptr         <= wgray_nxt;
      wfull        <= full_nxt;
      walmost_full <= af_nxt;
      wcount       <= cnt_nxt;
    end
  end

`ifdef FIFO_WR_OVF_FLAG_EN
  // Sticky flag: a write was attempted while full
  always_ff @(posedge clk) begin
    if (resetn) begin
      wovf <= 1'b0;
    end else if (winc & wfull) begin
      wovf <= 1'b1;
    end
  end
`else
  assign wovf = 1'b0;
`endif

endmodule
